// File: rtl/dit_fft.sv
// 16-point radix-2 DIT FFT over real samples: load bit-reversed, 32 in-place butterflies, stream 16 bins.
// Optional `define FFT_ROUND_EN switches every shift from truncation to round-half-up.
module dit_fft #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 24,
  parameter int TW_W  = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] in_x,
  input  logic                   in_nd,
  output logic [OUT_W-1:0]       out_x,
  output logic                   out_nd,
  output logic                   overflow
);
  localparam int IW  = IN_W + 2;
  localparam int IW1 = IW + 1;
  localparam int OW  = OUT_W / 2;
  localparam int PW  = IW + TW_W;
  localparam int SW  = PW + 1;

`ifdef FFT_ROUND_EN
  localparam int RND_TW = 512;
  localparam int RND_ST = 1;
`else
  localparam int RND_TW = 0;
  localparam int RND_ST = 0;
`endif

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

  state_t               r_state, w_state_nxt;
  logic [4:0]           r_cnt, w_cnt_nxt;
  logic                 w_load_we, w_calc_we, w_out_ld, w_out_nd_nxt;
  logic                 r_out_nd, r_overflow;
  logic [OUT_W-1:0]     r_out_x;
  logic signed [IW-1:0] r_ram_re [16];
  logic signed [IW-1:0] r_ram_im [16];

  function automatic logic signed [IW-1:0] sat_iw(input logic signed [SW-1:0] v);
    if (v[SW-1:IW-1] == {(SW-IW+1){v[SW-1]}}) return v[IW-1:0];
    return v[SW-1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
  endfunction

  function automatic logic [OW-1:0] sat_ow(input logic signed [IW-1:0] v);
    if (v[IW-1:OW-1] == {(IW-OW+1){v[IW-1]}}) return v[OW-1:0];
    return v[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
  endfunction

  // Butterfly addressing: stage s pairs (top, top + 2^s) and uses twiddle pos << (3-s).
  logic [1:0] w_stage;
  logic [2:0] w_bfly, w_k;
  logic [3:0] w_top, w_bot, w_load_addr;

  assign w_stage     = r_cnt[4:3];
  assign w_bfly      = r_cnt[2:0];
  assign w_load_addr = {r_cnt[0], r_cnt[1], r_cnt[2], r_cnt[3]};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_top = 4'd0;
    w_k   = 3'd0;
    unique case (w_stage)
      2'd0:    begin w_top = {w_bfly, 1'b0};                  w_k = 3'd0;                end
      2'd1:    begin w_top = {w_bfly[2:1], 1'b0, w_bfly[0]};  w_k = {w_bfly[0], 2'b00};  end
      2'd2:    begin w_top = {w_bfly[2], 1'b0, w_bfly[1:0]};  w_k = {w_bfly[1:0], 1'b0}; end
      default: begin w_top = {1'b0, w_bfly};                  w_k = w_bfly;              end
    endcase
  end
  assign w_bot = w_top | (4'd1 << w_stage);

  logic signed [TW_W-1:0] w_wr, w_wi;
  always_comb begin
    w_wr = TW_W'(1024);
    w_wi = TW_W'(0);
    case (w_k)
      3'd1:    begin w_wr = TW_W'(946);   w_wi = TW_W'(-392);  end
      3'd2:    begin w_wr = TW_W'(724);   w_wi = TW_W'(-724);  end
      3'd3:    begin w_wr = TW_W'(392);   w_wi = TW_W'(-946);  end
      3'd4:    begin w_wr = TW_W'(0);     w_wi = TW_W'(-1024); end
      3'd5:    begin w_wr = TW_W'(-392);  w_wi = TW_W'(-946);  end
      3'd6:    begin w_wr = TW_W'(-724);  w_wi = TW_W'(-724);  end
      3'd7:    begin w_wr = TW_W'(-946);  w_wi = TW_W'(-392);  end
      default: begin w_wr = TW_W'(1024);  w_wi = TW_W'(0);     end
    endcase
  end

  logic signed [IW-1:0]  w_a_re, w_a_im, w_b_re, w_b_im, w_bw_re, w_bw_im;
  logic signed [PW-1:0]  w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [IW1-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  assign w_a_re = r_ram_re[w_top];
  assign w_a_im = r_ram_im[w_top];
  assign w_b_re = r_ram_re[w_bot];
  assign w_b_im = r_ram_im[w_bot];

  assign w_p_rr = PW'(w_b_re) * PW'(w_wr);
  assign w_p_ii = PW'(w_b_im) * PW'(w_wi);
  assign w_p_ri = PW'(w_b_re) * PW'(w_wi);
  assign w_p_ir = PW'(w_b_im) * PW'(w_wr);

  assign w_bw_re = sat_iw((SW'(w_p_rr) - SW'(w_p_ii) + SW'(RND_TW)) >>> 10);
  assign w_bw_im = sat_iw((SW'(w_p_ri) + SW'(w_p_ir) + SW'(RND_TW)) >>> 10);

  assign w_sum_re = IW1'(w_a_re) + IW1'(w_bw_re) + IW1'(RND_ST);
  assign w_sum_im = IW1'(w_a_im) + IW1'(w_bw_im) + IW1'(RND_ST);
  assign w_dif_re = IW1'(w_a_re) - IW1'(w_bw_re) + IW1'(RND_ST);
  assign w_dif_im = IW1'(w_a_im) - IW1'(w_bw_im) + IW1'(RND_ST);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_load_we    = 1'b0;
    w_calc_we    = 1'b0;
    w_out_ld     = 1'b0;
    w_out_nd_nxt = 1'b0;
    unique case (r_state)
      S_LOAD: if (in_nd) begin
        w_load_we = 1'b1;
        if (r_cnt == 5'd15) begin w_state_nxt = S_CALC; w_cnt_nxt = 5'd0; end
        else                      w_cnt_nxt   = r_cnt + 5'd1;
      end
      S_CALC: begin
        w_calc_we = 1'b1;
        if (r_cnt == 5'd31) begin w_state_nxt = S_OUT; w_cnt_nxt = 5'd0; end
        else                      w_cnt_nxt   = r_cnt + 5'd1;
      end
      S_OUT: begin
        if (r_cnt == 5'd16) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = 5'd0;
        end else begin
          w_out_ld     = 1'b1;
          w_out_nd_nxt = 1'b1;
          w_cnt_nxt    = r_cnt + 5'd1;
        end
      end
      default: begin w_state_nxt = S_LOAD; w_cnt_nxt = 5'd0; end
    endcase
  end

  // NOTE: state uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_LOAD;
      r_cnt      <= 5'd0;
      r_out_x    <= '0;
      r_out_nd   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_out_nd <= w_out_nd_nxt;
      if (in_nd && r_state != S_LOAD) r_overflow <= 1'b1;
      if (w_out_ld) r_out_x <= {sat_ow(r_ram_re[r_cnt[3:0]]), sat_ow(r_ram_im[r_cnt[3:0]])};
    end
  end

  // NOTE: the working RAM has no reset; LOAD rewrites all 16 words before CALC reads any.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_load_we) begin
        r_ram_re[w_load_addr] <= IW'(in_x);
        r_ram_im[w_load_addr] <= '0;
      end
      if (w_calc_we) begin
        r_ram_re[w_top] <= sat_iw(SW'(w_sum_re >>> 1));
        r_ram_im[w_top] <= sat_iw(SW'(w_sum_im >>> 1));
        r_ram_re[w_bot] <= sat_iw(SW'(w_dif_re >>> 1));
        r_ram_im[w_bot] <= sat_iw(SW'(w_dif_im >>> 1));
      end
    end
  end

  assign out_x    = r_out_x;
  assign out_nd   = r_out_nd;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_dit_fft.sv
// Bench for dit_fft: floating-point DFT model fills a scoreboard per frame; a negedge monitor compares bins.
module tb_dit_fft;
  localparam int IN_W  = 24;
  localparam int OUT_W = 24;
  localparam int OW    = OUT_W / 2;
  localparam real PI   = 3.14159265358979;

  typedef int frame_t [16];
  typedef struct {
    int frame;
    int bin;
    int re;
    int im;
    int tol;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic signed [IN_W-1:0] in_x;
  logic                   in_nd;
  logic [OUT_W-1:0]       out_x;
  logic                   out_nd;
  logic                   overflow;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dit_fft #(.IN_W(IN_W), .OUT_W(OUT_W), .TW_W(12)) dut (
    .clk(clk), .reset(reset), .in_x(in_x), .in_nd(in_nd),
    .out_x(out_x), .out_nd(out_nd), .overflow(overflow)
  );

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_near(input string tag, input int observed, input int expected, input int tol);
    int d;
    d = observed - expected;
    if (d < 0) d = -d;
    n_checks++;
    assert (d <= tol) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, observed, expected, tol);
    end
  endtask

  // Ideal DFT scaled by 1/16, rounded and clamped to the output component range.
  function automatic void push_frame(input frame_t x, input int fid, input int tol0, input int tolk);
    for (int k = 0; k < 16; k++) begin
      real  re, im, ang;
      exp_t e;
      re = 0.0;
      im = 0.0;
      for (int n = 0; n < 16; n++) begin
        ang = 2.0 * PI * real'(k * n) / 16.0;
        re  = re + real'(x[n]) * $cos(ang);
        im  = im - real'(x[n]) * $sin(ang);
      end
      re = re / 16.0;
      im = im / 16.0;
      e.frame = fid;
      e.bin   = k;
      e.re    = $rtoi(re >= 0.0 ? re + 0.5 : re - 0.5);
      e.im    = $rtoi(im >= 0.0 ? im + 0.5 : im - 0.5);
      if (e.re > 2047) e.re = 2047;
      if (e.re < -2048) e.re = -2048;
      if (e.im > 2047) e.im = 2047;
      if (e.im < -2048) e.im = -2048;
      e.tol = (k == 0) ? tol0 : tolk;
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && out_nd) begin
      if (exp_q.size() == 0) begin
        check("unexpected out_nd", 1, 0);
      end else begin
        exp_t e;
        int   got_re, got_im;
        e      = exp_q.pop_front();
        got_re = $signed(out_x[OUT_W-1:OW]);
        got_im = $signed(out_x[OW-1:0]);
        check_near($sformatf("frame%0d bin%0d re", e.frame, e.bin), got_re, e.re, e.tol);
        check_near($sformatf("frame%0d bin%0d im", e.frame, e.bin), got_im, e.im, e.tol);
      end
    end
  end

  // NOTE: inputs change with blocking assignments on the falling edge, half a cycle clear of sampling.
  task automatic drive_frame(input frame_t x, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_x  = IN_W'(x[i]);
      in_nd = 1'b1;
      if (gaps && (i % 5 == 2)) begin
        @(negedge clk);
        in_nd = 1'b0;
        in_x  = IN_W'(77777);
      end
    end
  endtask

  // Called right after the 16th sample is placed; checks latency, burst length and scoreboard drain.
  task automatic wait_output(input string tag, input bit hold);
    int lat, hi;
    @(posedge clk);
    @(negedge clk);
    if (hold) in_x = IN_W'(5000);
    else      in_nd = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_nd) break;
    end
    check({tag, " latency"}, lat, 33);
    hi = 1;
    while (hi < 40) begin
      @(posedge clk);
      #1;
      if (!out_nd) break;
      hi++;
    end
    check({tag, " out_nd cycles"}, hi, 16);
    check({tag, " scoreboard drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    frame_t imp, dc, sine, neg;
    int     seen;
    imp  = '{default: 0};
    imp[0] = 1600;
    dc   = '{default: 100};
    sine = '{0, 38, 70, 92, 100, 92, 70, 38, 0, -38, -70, -92, -100, -92, -70, -38};
    neg  = '{default: -8388608};

    reset = 1'b1;
    in_nd = 1'b0;
    in_x  = '0;
    repeat (3) @(negedge clk);
    check("reset out_nd", int'(out_nd), 0);
    check("reset out_x", int'(out_x), 0);
    check("reset overflow", int'(overflow), 0);
    reset = 1'b0;

    push_frame(imp, 1, 0, 0);
    drive_frame(imp, 1'b0);
    wait_output("impulse", 1'b0);
    repeat (3) @(negedge clk);
    check("out_x holds last bin", int'(out_x), (100 << 12));
    check("overflow after impulse", int'(overflow), 0);

    push_frame(dc, 2, 0, 1);
    drive_frame(dc, 1'b1);
    wait_output("dc with gaps", 1'b0);

    push_frame(sine, 3, 2, 2);
    drive_frame(sine, 1'b0);
    wait_output("sine", 1'b0);
    check("overflow before held in_nd", int'(overflow), 0);

    push_frame(imp, 4, 0, 0);
    drive_frame(imp, 1'b0);
    wait_output("held A", 1'b1);
    check("overflow set by dropped samples", int'(overflow), 1);
    push_frame(dc, 5, 0, 1);
    drive_frame(dc, 1'b0);
    wait_output("held B", 1'b0);
    check("overflow sticky", int'(overflow), 1);

    drive_frame(imp, 1'b0);
    @(negedge clk);
    in_nd = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid-CALC reset out_nd", int'(out_nd), 0);
    check("mid-CALC reset overflow", int'(overflow), 0);
    check("mid-CALC reset out_x", int'(out_x), 0);
    reset = 1'b0;
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (out_nd) seen++;
    end
    check("no output from aborted frame", seen, 0);
    push_frame(imp, 6, 0, 0);
    drive_frame(imp, 1'b0);
    wait_output("impulse after reset", 1'b0);

    push_frame(neg, 7, 0, 1);
    drive_frame(neg, 1'b0);
    wait_output("saturating dc", 1'b0);
    check("overflow after clean frames", int'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
